if_prefetch_queue: RTL
======================

IF_PREFETCH_QUEUE -- requirements
Module: if_prefetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the FIFO entry count; it must be a power of 2 and at least 2.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port redirect_i, input, 1 bit: a taken branch/jump from EX.
REQ-006 SHALL have port redirect_pc_i, input, 32 bits: the redirect target.
REQ-007 SHALL have port imem_en_o, output, 1 bit: IMEM fetch request.
REQ-008 SHALL have port imem_addr_o, output, 32 bits: IMEM byte address.
REQ-009 SHALL have port imem_rdata_i, input, 32 bits: IMEM data, valid exactly 1 cycle after imem_en_o.
REQ-010 SHALL have port deq_valid_o, output, 1 bit: the head entry is valid.
REQ-011 SHALL have port deq_ready_i, input, 1 bit: ID accepts the head entry (ID not stalled).
REQ-012 SHALL have port deq_pc_o, output, 32 bits: PC of the head entry.
REQ-013 SHALL have port deq_instr_o, output, 32 bits: instruction of the head entry.
REQ-014 SHALL have port count_o, output, $clog2(DEPTH)+1 bits: FIFO occupancy.
REQ-015 SHALL have port pc_o, output, 32 bits: next fetch PC (debug).

Function
REQ-016 SHALL hold fetch_pc, a 1-bit inflight flag, and the PC tag of the in-flight request.
REQ-017 SHALL assert imem_en_o = !redirect_i && (count + inflight - deq_fire) < DEPTH, with deq_fire = deq_valid_o && deq_ready_i; imem_addr_o SHALL equal fetch_pc.
REQ-018 SHALL advance fetch_pc by 4 on each issue; the addition wraps modulo 2^32.
REQ-019 SHALL, in the cycle after an issue that was not killed, write {tag, imem_rdata_i} to the FIFO tail; that entry is first visible on deq_valid_o in the following cycle (2-cycle issue-to-dequeue latency).
REQ-020 SHALL present the head combinationally on deq_pc_o/deq_instr_o; deq_valid_o = (count != 0) && !redirect_i.
REQ-021 SHALL pop on deq_fire; a simultaneous push and pop SHALL leave count unchanged; read/write pointers wrap modulo DEPTH.
REQ-022 SHALL sustain 1 instruction per cycle with continuous deq_ready_i=1 for DEPTH >= 2.
REQ-023 SHALL hold the head stable while deq_valid_o=1 and deq_ready_i=0; when full, no issue occurs and no data is lost.
REQ-024 SHALL, on redirect_i, empty the FIFO (count 0), discard any response returning next cycle, and set fetch_pc <= {redirect_pc_i[31:2], 2'b00}; the first issue at the target SHALL occur in the next cycle.
REQ-025 SHALL give redirect priority over simultaneous dequeue, push, and issue in the same cycle.
REQ-026 SHALL, on back-to-back redirects, use only the last target.

Reset
REQ-027 SHALL, while rst_ni=0 at a clock edge, set fetch_pc=RESET_PC, inflight=0, pointers=0, count_o=0, deq_valid_o=0, imem_en_o=0.
REQ-028 SHALL discard any in-flight response when reset is asserted mid-operation; no write is produced after reset.
REQ-029 SHALL issue at RESET_PC in the first cycle with rst_ni=1.
REQ-030 SHALL leave FIFO storage uninitialised; only control state is reset.

Structure
REQ-031 SHALL take XLEN=32, ILEN=32 and the NOP encoding 32'h0000_0013 from the shared package rv32i_pkg.
REQ-032 SHALL instantiate one sub-module, sync_fifo (parametrised WIDTH, DEPTH), for entry storage and pointers; issue/credit/redirect logic stays in if_prefetch_queue.

Verification
REQ-033 Reset release with RESET_PC=0, deq_ready_i=1 -> imem_addr_o 0,4,8 on cycles 0,1,2; deq_valid_o first high on cycle 2 with deq_pc_o=0.
REQ-034 DEPTH=4, deq_ready_i=0 -> count_o saturates at 4, imem_en_o low thereafter; raising deq_ready_i restores in-order PCs with none skipped.
REQ-035 Redirect to 32'h0000_0102 while count=3 and a request is in flight -> count_o=0 next cycle, stale response dropped, next imem_addr_o=32'h0000_0100.
REQ-036 fetch_pc=32'hFFFF_FFFC, continuous flow -> next issue at 32'h0000_0000.
REQ-037 rst_ni low for 1 cycle with count=2 and a request in flight -> outputs at reset values, then restart at RESET_PC.
REQ-038 Random deq_ready_i and redirect every ~20 cycles -> dequeued PC sequence matches the scoreboard model, and count_o never exceeds DEPTH.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I constants used across the front-end blocks.
package rv32i_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;
  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

  // Fetch addresses are always word aligned.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_prefetch_queue_if.sv
// Signal bundle between the prefetch queue, instruction memory, EX redirect and ID.
interface if_prefetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  import rv32i_pkg::*;

  logic                    redirect;
  logic [XLEN-1:0]         redirect_pc;
  logic                    imem_en;
  logic [XLEN-1:0]         imem_addr;
  logic [ILEN-1:0]         imem_rdata;
  logic                    deq_valid;
  logic                    deq_ready;
  logic [XLEN-1:0]         deq_pc;
  logic [ILEN-1:0]         deq_instr;
  logic [$clog2(DEPTH):0]  count;
  logic [XLEN-1:0]         pc;

  // Prefetch unit side.
  modport master (
    input  redirect, redirect_pc, imem_rdata, deq_ready,
    output imem_en, imem_addr, deq_valid, deq_pc, deq_instr, count, pc
  );

  // Surrounding pipeline / memory side.
  modport slave (
    output redirect, redirect_pc, imem_rdata, deq_ready,
    input  imem_en, imem_addr, deq_valid, deq_pc, deq_instr, count, pc
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; storage is not reset, only pointers and count.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) wptr_d = wptr_q + PtrW'(1);
      if (pop_i)  rptr_d = rptr_q + PtrW'(1);
      count_d = count_q + (PtrW + 1)'(push_i) - (PtrW + 1)'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch: issues sequential IMEM fetches against FIFO credit, queues
// {pc, instr} for ID, and flushes on EX redirects.
module if_prefetch_queue
  import rv32i_pkg::*;
#(
  parameter int unsigned    DEPTH    = 4,
  parameter logic [31:0]    RESET_PC = 32'h0000_0000
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   redirect_i,
  input  logic [XLEN-1:0]        redirect_pc_i,
  output logic                   imem_en_o,
  output logic [XLEN-1:0]        imem_addr_o,
  input  logic [ILEN-1:0]        imem_rdata_i,
  output logic                   deq_valid_o,
  input  logic                   deq_ready_i,
  output logic [XLEN-1:0]        deq_pc_o,
  output logic [ILEN-1:0]        deq_instr_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [XLEN-1:0]        pc_o
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned SumW = CntW + 1;

  logic [XLEN-1:0]      fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]      tag_q, tag_d;
  logic                 inflight_q, inflight_d;
  logic                 deq_fire, push;
  logic [SumW-1:0]      credits;
  logic [XLEN+ILEN-1:0] fifo_rdata;

  assign deq_valid_o = (count_o != '0) && !redirect_i;
  assign deq_fire    = deq_valid_o && deq_ready_i;

  // The in-flight request already owns a slot; a pop this cycle frees one.
  assign credits   = SumW'(count_o) + SumW'(inflight_q) - SumW'(deq_fire);
  assign imem_en_o = rst_ni && !redirect_i && (credits < SumW'(DEPTH));
  assign imem_addr_o = fetch_pc_q;
  assign pc_o        = fetch_pc_q;

  // A response landing in a redirect cycle belongs to the wrong path.
  assign push = inflight_q && !redirect_i;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    tag_d      = tag_q;
    inflight_d = imem_en_o;
    if (redirect_i) begin
      fetch_pc_d = align_pc(redirect_pc_i);
    end else if (imem_en_o) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      tag_d      = fetch_pc_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fetch_pc_q <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

  sync_fifo #(
    .WIDTH (XLEN + ILEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (redirect_i),
    .push_i  (push),
    .wdata_i ({tag_q, imem_rdata_i}),
    .pop_i   (deq_fire),
    .rdata_o (fifo_rdata),
    .count_o (count_o)
  );

  assign deq_pc_o    = fifo_rdata[XLEN+ILEN-1:ILEN];
  assign deq_instr_o = fifo_rdata[ILEN-1:0];

endmodule
